// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the IF/MEM byte-wide memory arbiter.
package mem_arbiter_pkg;

   // FSM state encodings
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // mem_len codes (11 is treated like a word access)
   localparam logic [1:0] LEN_B = 2'b00;
   localparam logic [1:0] LEN_H = 2'b01;
   localparam logic [1:0] LEN_W = 2'b10;

   // Owner of the transaction currently in flight
   localparam logic OWN_IF  = 1'b0;
   localparam logic OWN_MEM = 1'b1;

   // Number of RAM byte cycles an access of the given length needs
   function automatic logic [2:0] lenToBytes(input logic [1:0] len);
      case (len)
         LEN_B:   return 3'd1;
         LEN_H:   return 3'd2;
         LEN_W:   return 3'd4;
         default: return 3'd4;
      endcase
   endfunction

   // Little-endian byte lane select
   function automatic logic [7:0] byteOf(input logic [31:0] word, input logic [1:0] idx);
      case (idx)
         2'd0:    return word[7:0];
         2'd1:    return word[15:8];
         2'd2:    return word[23:16];
         default: return word[31:24];
      endcase
   endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates IF and MEM requesters onto a single byte-wide RAM port.
// MEM has fixed priority; each grant is serialised into single-byte RAM
// cycles and finished with a one-cycle done pulse to its owner.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_done_o,
   output logic [31:0]       if_data_o,
   input  logic              mem_req_i,
   input  logic              mem_we_i,
   input  logic [1:0]        mem_len_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [31:0]       mem_wdata_i,
   output logic              mem_done_o,
   output logic [31:0]       mem_rdata_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic              ram_wr_o,
   output logic [7:0]        ram_dout_o,
   input  logic [7:0]        ram_din_i
);

   logic [1:0]        state_q,    state_d;
   logic              owner_q,    owner_d;
   logic              we_q,       we_d;
   logic [2:0]        nBytes_q,   nBytes_d;
   logic [2:0]        cnt_q,      cnt_d;
   logic [ADDR_W-1:0] base_q,     base_d;
   logic [31:0]       wdata_q,    wdata_d;
   logic [31:0]       result_q,   result_d;
   logic [ADDR_W-1:0] ramAddr_q,  ramAddr_d;
   logic              ramWr_q,    ramWr_d;
   logic [7:0]        ramDout_q,  ramDout_d;
   logic              ifDone_q,   ifDone_d;
   logic [31:0]       ifData_q,   ifData_d;
   logic              memDone_q,  memDone_d;
   logic [31:0]       memRdata_q, memRdata_d;

   logic [2:0] cntNext;
   logic [1:0] rdIdx;

   // Byte counter step and the lane the byte arriving this cycle belongs to
   // (the read byte lags its address by one cycle, hence cnt-1).
   always_comb begin
      cntNext = cnt_q + 3'd1;
      rdIdx   = cnt_q[1:0] - 2'd1;
   end

   // Next-state logic: grant, byte sequencing, read assembly and done pulses
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      we_d       = we_q;
      nBytes_d   = nBytes_q;
      cnt_d      = cnt_q;
      base_d     = base_q;
      wdata_d    = wdata_q;
      result_d   = result_q;
      ramAddr_d  = ramAddr_q;
      ramWr_d    = 1'b0;
      ramDout_d  = ramDout_q;
      ifDone_d   = 1'b0;
      ifData_d   = ifData_q;
      memDone_d  = 1'b0;
      memRdata_d = memRdata_q;

      case (state_q)
         ST_IDLE: begin
            if (mem_req_i) begin
               state_d   = ST_RUN;
               owner_d   = OWN_MEM;
               we_d      = mem_we_i;
               nBytes_d  = lenToBytes(mem_len_i);
               base_d    = mem_addr_i;
               wdata_d   = mem_wdata_i;
               cnt_d     = 3'd0;
               result_d  = 32'd0;
               ramAddr_d = mem_addr_i;
               ramWr_d   = mem_we_i;
               if (mem_we_i) begin
                  ramDout_d = mem_wdata_i[7:0];
               end
            end else if (if_req_i) begin
               state_d   = ST_RUN;
               owner_d   = OWN_IF;
               we_d      = 1'b0;
               nBytes_d  = 3'd4;
               base_d    = if_addr_i;
               cnt_d     = 3'd0;
               result_d  = 32'd0;
               ramAddr_d = if_addr_i;
            end
         end

         ST_RUN: begin
            if ((owner_q == OWN_IF) && !if_req_i) begin
               state_d = ST_IDLE;
               cnt_d   = 3'd0;
            end else if (we_q) begin
               if (cnt_q == nBytes_q - 3'd1) begin
                  state_d   = ST_DONE;
                  cnt_d     = 3'd0;
                  memDone_d = (owner_q == OWN_MEM);
                  ifDone_d  = (owner_q == OWN_IF);
               end else begin
                  cnt_d     = cntNext;
                  ramAddr_d = base_q + ADDR_W'(cntNext);
                  ramWr_d   = 1'b1;
                  ramDout_d = byteOf(wdata_q, cntNext[1:0]);
               end
            end else begin
               if (cnt_q != 3'd0) begin
                  case (rdIdx)
                     2'd0:    result_d[7:0]   = ram_din_i;
                     2'd1:    result_d[15:8]  = ram_din_i;
                     2'd2:    result_d[23:16] = ram_din_i;
                     default: result_d[31:24] = ram_din_i;
                  endcase
               end
               if (cnt_q == nBytes_q) begin
                  state_d = ST_DONE;
                  cnt_d   = 3'd0;
                  if (owner_q == OWN_MEM) begin
                     memDone_d  = 1'b1;
                     memRdata_d = result_d;
                  end else begin
                     ifDone_d = 1'b1;
                     ifData_d = result_d;
                  end
               end else begin
                  cnt_d = cntNext;
                  if (cntNext < nBytes_q) begin
                     ramAddr_d = base_q + ADDR_W'(cntNext);
                  end
               end
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
         end
      endcase
   end

   // State and registered outputs; synchronous active-low reset clears everything
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q    <= ST_IDLE;
         owner_q    <= OWN_IF;
         we_q       <= 1'b0;
         nBytes_q   <= 3'd0;
         cnt_q      <= 3'd0;
         base_q     <= '0;
         wdata_q    <= 32'd0;
         result_q   <= 32'd0;
         ramAddr_q  <= '0;
         ramWr_q    <= 1'b0;
         ramDout_q  <= 8'd0;
         ifDone_q   <= 1'b0;
         ifData_q   <= 32'd0;
         memDone_q  <= 1'b0;
         memRdata_q <= 32'd0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         we_q       <= we_d;
         nBytes_q   <= nBytes_d;
         cnt_q      <= cnt_d;
         base_q     <= base_d;
         wdata_q    <= wdata_d;
         result_q   <= result_d;
         ramAddr_q  <= ramAddr_d;
         ramWr_q    <= ramWr_d;
         ramDout_q  <= ramDout_d;
         ifDone_q   <= ifDone_d;
         ifData_q   <= ifData_d;
         memDone_q  <= memDone_d;
         memRdata_q <= memRdata_d;
      end
   end

   assign if_done_o   = ifDone_q;
   assign if_data_o   = ifData_q;
   assign mem_done_o  = memDone_q;
   assign mem_rdata_o = memRdata_q;
   assign ram_addr_o  = ramAddr_q;
   assign ram_wr_o    = ramWr_q;
   assign ram_dout_o  = ramDout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table plus scoreboard queues
// for RAM writes and done pulses, and hand sequences for multi-cycle corners.
module tb_mem_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic        if_done_o;
   logic [31:0] if_data_o;
   logic        mem_req_i;
   logic        mem_we_i;
   logic [1:0]  mem_len_i;
   logic [31:0] mem_addr_i;
   logic [31:0] mem_wdata_i;
   logic        mem_done_o;
   logic [31:0] mem_rdata_o;
   logic [31:0] ram_addr_o;
   logic        ram_wr_o;
   logic [7:0]  ram_dout_o;
   logic [7:0]  ram_din_i;

   mem_arbiter #(.ADDR_W(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i),
      .if_done_o(if_done_o), .if_data_o(if_data_o),
      .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_len_i(mem_len_i),
      .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
      .mem_done_o(mem_done_o), .mem_rdata_o(mem_rdata_o),
      .ram_addr_o(ram_addr_o), .ram_wr_o(ram_wr_o),
      .ram_dout_o(ram_dout_o), .ram_din_i(ram_din_i)
   );

   // Free-running clock
   always #5 clk_i = ~clk_i;

   // RAM model: 256-byte image aliased on the low address byte, read data
   // returned one cycle after the address is presented
   logic [7:0] ramModel [256];
   logic [7:0] ramAddrQ = 8'd0;
   always @(posedge clk_i) ramAddrQ <= ram_addr_o[7:0];
   assign ram_din_i = ramModel[ramAddrQ];

   typedef struct {
      bit          isMem;
      bit          we;
      logic [1:0]  len;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [7:0]  b0, b1, b2, b3;
      logic [31:0] expData;
      int          expLat;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  data;
   } wrExp_t;

   typedef struct {
      bit          isMem;
      bit          checkData;
      logic [31:0] data;
   } doneExp_t;

   wrExp_t   expWrQ[$];
   doneExp_t expDoneQ[$];

   int vecCount  = 0;
   int missCount = 0;
   bit doneFlag;

   vec_t vecs [8];

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecCount++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic int lenBytes(input bit isMem, input logic [1:0] len);
      if (!isMem) return 4;
      if (len == 2'b00) return 1;
      if (len == 2'b01) return 2;
      return 4;
   endfunction

   // Per-negedge monitor: pops the scoreboard on every RAM write and done pulse
   task automatic checkOutput();
      wrExp_t   w;
      doneExp_t d;
      doneFlag = 1'b0;
      if (ram_wr_o) begin
         if (expWrQ.size() == 0) begin
            cmp("unexpected ram write addr", ram_addr_o, 32'hFFFF_FFFF ^ ram_addr_o);
         end else begin
            w = expWrQ.pop_front();
            cmp("write addr", ram_addr_o, w.addr);
            cmp("write data", {24'd0, ram_dout_o}, {24'd0, w.data});
         end
      end
      if (if_done_o || mem_done_o) begin
         doneFlag = 1'b1;
         if (expDoneQ.size() == 0) begin
            cmp("unexpected done {mem,if}", {30'd0, mem_done_o, if_done_o}, 32'd0);
         end else begin
            d = expDoneQ.pop_front();
            cmp("done owner {mem,if}", {30'd0, mem_done_o, if_done_o},
                d.isMem ? 32'd2 : 32'd1);
            if (d.checkData)
               cmp("read data", d.isMem ? mem_rdata_o : if_data_o, d.data);
         end
      end
   endtask

   task automatic tick();
      @(negedge clk_i);
      checkOutput();
   endtask

   // Drive one transaction; the grant edge comes extraWait cycles after the
   // next posedge (1 when issued from a DONE cycle, which ignores requests)
   task automatic applyStimulus(input vec_t v, input int extraWait);
      int          n;
      int          lat;
      bit          seen;
      logic [31:0] sh;
      wrExp_t      w;
      doneExp_t    d;
      n = lenBytes(v.isMem, v.len);
      ramModel[8'(v.addr + 32'd0)] = v.b0;
      ramModel[8'(v.addr + 32'd1)] = v.b1;
      ramModel[8'(v.addr + 32'd2)] = v.b2;
      ramModel[8'(v.addr + 32'd3)] = v.b3;
      if (v.we) begin
         for (int k = 0; k < n; k++) begin
            sh     = v.wdata >> (8 * k);
            w.addr = v.addr + 32'(k);
            w.data = sh[7:0];
            expWrQ.push_back(w);
         end
      end
      d.isMem     = v.isMem;
      d.checkData = !v.we;
      d.data      = v.expData;
      expDoneQ.push_back(d);
      if (v.isMem) begin
         mem_req_i   = 1'b1;
         mem_we_i    = v.we;
         mem_len_i   = v.len;
         mem_addr_i  = v.addr;
         mem_wdata_i = v.wdata;
      end else begin
         if_req_i  = 1'b1;
         if_addr_i = v.addr;
      end
      seen = 1'b0;
      lat  = 0;
      for (int i = 1; i <= 30 && !seen; i++) begin
         tick();
         if (!v.we && i > extraWait && i <= extraWait + n)
            cmp("read addr", ram_addr_o, v.addr + 32'(i - extraWait - 1));
         if (doneFlag) begin
            seen = 1'b1;
            lat  = i;
         end
      end
      if (!seen) cmp("done timeout", 32'd0, 32'd1);
      else       cmp("done latency", 32'(lat), 32'(v.expLat + extraWait));
      if (v.isMem) mem_req_i = 1'b0;
      else         if_req_i  = 1'b0;
   endtask

   initial begin
      int   memAt;
      int   ifAt;
      vec_t v;

      //           isMem we  len    addr           wdata          b0     b1     b2     b3     expData        lat
      vecs[0] = '{1'b0, 1'b0, 2'b10, 32'h0000_1000, 32'h0,         8'h11, 8'h22, 8'h33, 8'h44, 32'h4433_2211, 6};
      vecs[1] = '{1'b0, 1'b0, 2'b10, 32'h0000_2000, 32'h0,         8'hDE, 8'hAD, 8'hBE, 8'hEF, 32'hEFBE_ADDE, 6};
      vecs[2] = '{1'b1, 1'b1, 2'b00, 32'h0000_0020, 32'hDEAD_BEEF, 8'h00, 8'h00, 8'h00, 8'h00, 32'h0,         2};
      vecs[3] = '{1'b1, 1'b0, 2'b01, 32'hFFFF_FFFF, 32'h0,         8'hAA, 8'hBB, 8'h99, 8'h88, 32'h0000_BBAA, 4};
      vecs[4] = '{1'b1, 1'b0, 2'b00, 32'h0000_0055, 32'h0,         8'h5A, 8'hC3, 8'h3C, 8'h77, 32'h0000_005A, 3};
      vecs[5] = '{1'b1, 1'b0, 2'b10, 32'h0000_0080, 32'h0,         8'h01, 8'h02, 8'h03, 8'h04, 32'h0403_0201, 6};
      vecs[6] = '{1'b1, 1'b1, 2'b01, 32'h0000_0040, 32'h1234_5678, 8'h00, 8'h00, 8'h00, 8'h00, 32'h0,         3};
      vecs[7] = '{1'b1, 1'b1, 2'b11, 32'h0000_007C, 32'hCAFE_F00D, 8'h00, 8'h00, 8'h00, 8'h00, 32'h0,         5};

      for (int i = 0; i < 256; i++) ramModel[i] = 8'h00;
      rst_i = 1'b0; if_req_i = 1'b0; if_addr_i = 32'd0;
      mem_req_i = 1'b0; mem_we_i = 1'b0; mem_len_i = 2'b00;
      mem_addr_i = 32'd0; mem_wdata_i = 32'd0;

      // Reset state
      tick();
      tick();
      cmp("reset ram_wr", {31'd0, ram_wr_o}, 32'd0);
      cmp("reset ram_addr", ram_addr_o, 32'd0);
      cmp("reset if_done", {31'd0, if_done_o}, 32'd0);
      cmp("reset mem_done", {31'd0, mem_done_o}, 32'd0);
      cmp("reset if_data", if_data_o, 32'd0);
      cmp("reset mem_rdata", mem_rdata_o, 32'd0);
      rst_i = 1'b1;
      tick();

      // Vector table; later vectors are issued from the previous DONE cycle
      for (int i = 0; i < 8; i++) applyStimulus(vecs[i], (i == 0) ? 0 : 1);
      tick();

      // Both requesters raise together: MEM first, IF in the next IDLE
      ramModel[8'h80] = 8'hA1; ramModel[8'h81] = 8'hB2;
      ramModel[8'h82] = 8'hC3; ramModel[8'h83] = 8'hD4;
      ramModel[8'h00] = 8'h10; ramModel[8'h01] = 8'h20;
      ramModel[8'h02] = 8'h30; ramModel[8'h03] = 8'h40;
      expDoneQ.push_back('{1'b1, 1'b1, 32'hD4C3_B2A1});
      expDoneQ.push_back('{1'b0, 1'b1, 32'h4030_2010});
      mem_req_i = 1'b1; mem_we_i = 1'b0; mem_len_i = 2'b10; mem_addr_i = 32'h80;
      if_req_i  = 1'b1; if_addr_i = 32'h3000;
      memAt = 0; ifAt = 0;
      for (int i = 1; i <= 40 && ifAt == 0; i++) begin
         tick();
         if (mem_done_o) begin memAt = i; mem_req_i = 1'b0; end
         if (if_done_o)  begin ifAt  = i; if_req_i  = 1'b0; end
      end
      mem_req_i = 1'b0; if_req_i = 1'b0;
      cmp("simultaneous mem done cycle", 32'(memAt), 32'd6);
      cmp("simultaneous if done cycle", 32'(ifAt), 32'd13);
      tick();

      // IF abort after RUN cycle 1, then a MEM request granted right away
      if_req_i = 1'b1; if_addr_i = 32'h0000_1000;
      tick();
      tick();
      if_req_i = 1'b0;
      tick();
      cmp("abort addr hold", ram_addr_o, 32'h0000_1001);
      cmp("abort if_data hold", if_data_o, 32'h4030_2010);
      v = '{1'b1, 1'b1, 2'b00, 32'h0000_0033, 32'h0000_0077, 8'h00, 8'h00, 8'h00, 8'h00, 32'h0, 2};
      applyStimulus(v, 0);
      tick();

      // Reset in RUN cycle 2 of a MEM word write
      expWrQ.push_back('{32'h60, 8'h44});
      expWrQ.push_back('{32'h61, 8'h33});
      expWrQ.push_back('{32'h62, 8'h22});
      mem_req_i = 1'b1; mem_we_i = 1'b1; mem_len_i = 2'b10;
      mem_addr_i = 32'h60; mem_wdata_i = 32'h1122_3344;
      tick();
      tick();
      tick();
      rst_i = 1'b0;
      tick();
      cmp("midreset ram_wr", {31'd0, ram_wr_o}, 32'd0);
      cmp("midreset ram_addr", ram_addr_o, 32'd0);
      cmp("midreset ram_dout", {24'd0, ram_dout_o}, 32'd0);
      cmp("midreset mem_done", {31'd0, mem_done_o}, 32'd0);
      cmp("midreset if_data", if_data_o, 32'd0);
      cmp("midreset mem_rdata", mem_rdata_o, 32'd0);
      rst_i = 1'b1; mem_req_i = 1'b0;
      tick();
      applyStimulus(vecs[7], 0);

      for (int i = 0; i < 3; i++) tick();
      cmp("write queue drained", 32'(expWrQ.size()), 32'd0);
      cmp("done queue drained", 32'(expDoneQ.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits between the instruction-fetch (IF) and memory-stage (MEM) requesters and the single byte-wide RAM port.
- Arbitrates between the two requesters; MEM has fixed priority.
- Sequences each granted 1/2/4-byte access into consecutive single-byte RAM cycles, then returns assembled read data or a write completion as a one-cycle done pulse.

Parameters:
- ADDR_W, 32, width of byte addresses on every address port.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-low reset.
- if_req_i  in  1  IF read request; held until if_done_o.
- if_addr_i  in  ADDR_W  IF byte address; always a 4-byte read.
- if_done_o  out  1  one-cycle pulse; if_data_o valid in that cycle.
- if_data_o  out  32  fetched word, little-endian.
- mem_req_i  in  1  MEM request; held until mem_done_o.
- mem_we_i  in  1  1 = write, 0 = read.
- mem_len_i  in  2  00 = 1 byte, 01 = 2 bytes, 10 and 11 = 4 bytes.
- mem_addr_i  in  ADDR_W  MEM base byte address.
- mem_wdata_i  in  32  write data; byte k = bits [8k+7:8k].
- mem_done_o  out  1  one-cycle pulse; mem_rdata_o valid in that cycle for reads.
- mem_rdata_o  out  32  read data, zero-filled above N bytes.
- ram_addr_o  out  ADDR_W  RAM byte address.
- ram_wr_o  out  1  RAM write strobe.
- ram_dout_o  out  8  RAM write byte.
- ram_din_i  in  8  RAM read byte; valid one cycle after its address is driven.

Behaviour:
- Reset (rst_i low at posedge):
  - FSM goes to IDLE; byte counter cleared.
  - All outputs go to 0, including ram_wr_o, both done pulses and both data outputs.
  - Applies in any state, including mid-write. Bytes already written stay written; no done pulse is issued.
- States: IDLE, RUN, DONE.
- IDLE:
  - At each posedge, if mem_req_i=1, grant MEM. Else if if_req_i=1, grant IF. Else stay.
  - On grant, latch owner, we, N (1/2/4) and base address. Go to RUN.
- RUN, cycle k = 0 .. N-1 (cycle 0 is the cycle after the grant posedge):
  - ram_addr_o = base + k, modulo 2^ADDR_W (wraps to 0).
  - For writes: ram_wr_o = 1 and ram_dout_o = wdata byte k.
- RUN, reads:
  - ram_din_i in cycle k+1 is byte k. It is stored into result bits [8k+7:8k] at the end of cycle k+1.
  - Leave RUN at the end of cycle N, so RUN lasts N+1 cycles.
  - ram_wr_o = 0 throughout.
  - ram_addr_o holds base+N-1 in cycle N.
- RUN, writes: leave RUN at the end of cycle N-1, so RUN lasts N cycles.
- DONE (exactly 1 cycle):
  - The owner's done_o = 1; its data output holds the result.
  - ram_wr_o = 0.
  - Requests are ignored in this cycle (turnaround, because requesters drop req on the edge leaving DONE).
  - Next state is IDLE.
- Latency, grant posedge to first DONE cycle: reads N+2 cycles, writes N+1 cycles. IF word read: 6 cycles, plus 1 idle cycle before the next grant.
- No preemption: a MEM request arriving during an IF transaction waits for IDLE.
- IF abort: if if_req_i is 0 at any RUN posedge of an IF transaction, go to IDLE at that edge. No if_done_o is issued and partial data is discarded; this is safe because reads have no side effects.
- MEM transactions cannot be aborted. mem_req_i dropping mid-transaction is ignored, and mem_done_o is still issued.
- Outside DONE:
  - done outputs are 0.
  - Data outputs hold their last value.
  - ram_addr_o holds its last value.
  - ram_dout_o holds its last value.
- Inputs are sampled only at the grant; changes during RUN are ignored except the IF abort rule.

Decomposition:
- Add to the shared defines.v:
  - state encodings IDLE/RUN/DONE;
  - mem_len codes LEN_B/LEN_H/LEN_W;
  - owner codes OWN_IF/OWN_MEM.
- Single flat module, no sub-module; the byte counter and shift/assembly logic are small enough to inline.

Test Plan:
- IF word read of 0x1000, RAM bytes 11,22,33,44:
  - ram_addr_o runs 0x1000..0x1003 with ram_wr_o=0.
  - if_done_o pulses 6 cycles after the grant, if_data_o=0x44332211.
  - Next IF grant comes no earlier than 1 cycle later.
- MEM byte write, addr 0x20, wdata 0xDEADBEEF, len 00:
  - Exactly one cycle with ram_wr_o=1, ram_addr_o=0x20, ram_dout_o=0xEF.
  - mem_done_o pulses 2 cycles after the grant.
- if_req_i and mem_req_i rise together, both word reads:
  - MEM served first; IF granted in the first IDLE after MEM's DONE.
  - Each requester sees exactly one done pulse.
- MEM half read at 0xFFFFFFFF:
  - ram_addr_o goes 0xFFFFFFFF then 0x00000000.
  - mem_rdata_o=0x0000BBAA for bytes AA,BB.
- IF word read with if_req_i dropped after RUN cycle 1:
  - FSM reaches IDLE with no if_done_o.
  - A subsequent MEM request is granted on the next posedge.
- MEM word write with rst_i low in RUN cycle 2:
  - ram_wr_o=0 from that edge on; all outputs 0; no mem_done_o.
  - After release, a new MEM write completes normally.
